mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//   Instruction fetch stage feeding the mips32 R-type datapath. Owns the PC,
//   issues word reads to a synchronous instruction memory (1-cycle read latency)
//   and buffers returned words in a prefetch FIFO.
//   Presents instructions downstream over a valid/ready handshake.
//   Stops on a HALT sentinel word.
// PARAMETERS
//   FIFO_DEPTH  4             prefetch FIFO entries (power of 2, >=2)
//   HALT_WORD   32'hFFFF_FFFF instruction word that terminates a fetch run
//   CNT_WIDTH   16            width of fetch_count
// PORTS
//   clk          in   1          system clock, all state on rising edge
//   rst_n        in   1          synchronous reset, active low
//   start        in   1          begin fetch run (sampled only in IDLE)
//   start_pc     in   32         first fetch address; bits[1:0] forced to 0
//   imem_req     out  1          read request to instruction memory
//   imem_addr    out  32         word-aligned read address
//   imem_rdata   in   32         read data, valid the cycle after imem_req
//   instr_out    out  32         instruction to datapath (FIFO head)
//   instr_pc     out  32         address of instr_out
//   instr_valid  out  1          instr_out/instr_pc valid
//   instr_ready  in   1          datapath accepts head this cycle
//   busy         out  1          state != IDLE
//   fetch_count  out  CNT_WIDTH  instructions handed off since last start
// BEHAVIOUR
// - Reset (rst_n=0 at an edge):
//   - state=IDLE, pc=0, FIFO empty, inflight=0.
//   - Outputs: imem_req=0, imem_addr=0, instr_valid=0, instr_out=0,
//     instr_pc=0, busy=0, fetch_count=0.
//   - Reset overrides all inputs. Reset mid-run discards FIFO contents and any
//     in-flight response.
// - FSM: IDLE -> FETCH on start; FETCH -> DRAIN when HALT_WORD returns;
//   DRAIN -> IDLE when FIFO empty and inflight=0.
//   - start outside IDLE is ignored.
//   - On start: pc<=start_pc&~3, fetch_count<=0.
// - Issue (FETCH only):
//   - imem_req=1 iff (fifo_count + inflight) < FIFO_DEPTH.
//   - imem_addr=pc; on issue pc<=pc+4, wrapping modulo 2^32.
//   - inflight (0/1) is set on issue and cleared on response; a new issue may
//     overlap a response in the same cycle.
// - Response (cycle after issue):
//   - In FETCH, imem_rdata != HALT_WORD: push {rdata, addr} into FIFO.
//   - In FETCH, imem_rdata == HALT_WORD: not pushed; state->DRAIN.
//   - A response returning in DRAIN or IDLE (the request issued alongside the
//     halt response) is discarded.
// - FIFO:
//   - Registered; no bypass. A pushed word is visible on instr_out the cycle
//     after the push.
//   - instr_valid = !empty; pop on instr_valid & instr_ready.
//   - Simultaneous push+pop keeps count unchanged.
//   - The credit rule makes push-when-full impossible; the bench asserts it.
//   - instr_out/instr_pc hold stable while valid & !ready.
// - fetch_count increments on each pop, saturates at all-ones, clears only on
//   reset or start.
// - Latency: start high in cycle 0 -> imem_req=1, imem_addr=start_pc in
//   cycle 1 -> data in cycle 2 -> instr_valid=1 in cycle 3.
//   Sustained throughput 1 instr/cycle with instr_ready=1.
// - Empty and draining: busy stays 1 until the last FIFO entry is popped.
// TESTING
//   1) Reset: rst_n=0 two cycles with start=1 -> all outputs 0, state IDLE,
//      no imem_req.
//   2) Stream: mem[0..3]=A,B,C,HALT; start_pc=0, ready=1
//      -> A@0 in cycle 3, B@4, C@8 on consecutive cycles.
//      Then busy=0 and fetch_count=3; addr 0x10 response discarded.
//   3) Backpressure: ready=0 with FIFO_DEPTH=4 -> exactly 4 entries queued,
//      imem_req stays 0, instr_out stable.
//      ready=1 -> in-order drain with no loss or duplication.
//   4) Wrap: start_pc=0xFFFF_FFFE
//      -> first addr 0xFFFF_FFFC, next 0x0000_0000.
//   5) Reset mid-run: rst_n=0 while FIFO holds 2 entries and a request is in
//      flight -> next cycle instr_valid=0, busy=0.
//      Late imem_rdata is ignored and not pushed.
//   6) start pulsed during FETCH -> ignored; pc and fetch_count unaffected.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited reads to a 1-cycle
// instruction memory and hands buffered words downstream over valid/ready.
module mips_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          start_pc,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr_out,
    output logic [31:0]          instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]      pc;
    logic             inflight;
    logic [31:0]      inflight_addr;

    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] fifo_count;

    logic             fifo_empty;
    logic [OCC_W-1:0] occupancy;
    logic             issue;
    logic             resp_in_fetch;
    logic             resp_halt;
    logic             push;
    logic             pop;
    logic             run_start;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        fifo_empty    = (fifo_count == '0);
        occupancy     = fifo_count + OCC_W'(inflight);
        run_start     = (state == IDLE) && start;
        // Credit counts the in-flight word so a response always has a free slot.
        issue         = (state == FETCH) && (occupancy < DEPTH_OCC);
        resp_in_fetch = inflight && (state == FETCH);
        resp_halt     = resp_in_fetch && (imem_rdata == HALT_WORD);
        push          = resp_in_fetch && !resp_halt;
        pop           = !fifo_empty && instr_ready;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)                     state_next = FETCH;
            FETCH:   if (resp_halt)                 state_next = DRAIN;
            DRAIN:   if (fifo_empty && !inflight)   state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            fetch_count   <= '0;
        end else begin
            state    <= state_next;
            // Response latency is exactly one cycle, so the flag simply follows issue.
            inflight <= issue;

            if (run_start) begin
                pc <= start_pc & 32'hFFFF_FFFC;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            if (issue) begin
                inflight_addr <= pc;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (run_start) begin
                fetch_count <= '0;
            end else if (pop && (fetch_count != '1)) begin
                fetch_count <= fetch_count + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: the storage array carries no reset; validity is tracked entirely by
    // the pointers and count, and stale entries are masked on the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= inflight_addr;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign instr_valid = !fifo_empty;
    assign instr_out   = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign instr_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr];
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed latency/boundary cases plus
// randomized runs compared against a program-level reference model.
module tb_mips_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic [15:0] fetch_count;

    mips_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .HALT_WORD  (HALT),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: 256 words, aliased across the address space.
    logic [31:0] mem [256];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:2]] = w;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
    endtask

    task automatic put_program(input logic [31:0] base, input int len);
        logic [31:0] a;
        a = base & 32'hFFFF_FFFC;
        for (int k = 0; k < len; k++) begin
            put(a, rand_word());
            a = a + 32'd4;
        end
        put(a, HALT);
    endtask

    // Synchronous memory: a request seen this cycle returns data next cycle.
    initial begin : imem_model
        logic        cap_req;
        logic [31:0] cap_addr;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            cap_req  = imem_req;
            cap_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rdata = cap_req ? word_at(cap_addr) : $urandom;
        end
    end

    // Reference model: a run delivers the words from start_pc upward, in order,
    // stopping before the first HALT word.
    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } instr_t;

    instr_t      exp_q[$];
    int          pushed       = 0;
    int          popped       = 0;
    int          accepted     = 0;
    logic        halt_seen    = 1'b0;
    logic        run_active   = 1'b0;
    logic        req_prev     = 1'b0;
    logic [31:0] addr_prev    = 32'h0;
    logic [31:0] next_addr    = 32'h0;
    logic        hold_pending = 1'b0;
    logic [31:0] held_out     = 32'h0;
    logic [31:0] held_pc      = 32'h0;

    task automatic build_expected(input logic [31:0] pc0);
        logic [31:0] a;
        logic [31:0] w;
        instr_t      e;
        exp_q.delete();
        a = pc0 & 32'hFFFF_FFFC;
        for (int k = 0; k < 256; k++) begin
            w = word_at(a);
            if (w == HALT) break;
            e.data = w;
            e.pc   = a;
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    initial begin : monitor
        logic        resp_this;
        logic [31:0] resp_word;
        instr_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pushed = 0; popped = 0; accepted = 0;
                halt_seen = 1'b0; run_active = 1'b0; req_prev = 1'b0;
                hold_pending = 1'b0; next_addr = 32'h0;
                continue;
            end
            resp_this = req_prev;
            resp_word = word_at(addr_prev);

            check("fetch_count", 32'(fetch_count), 32'(accepted));
            check("req_after_halt", 32'(imem_req & halt_seen), 32'd0);
            check("req_outside_run", 32'(imem_req & ~run_active), 32'd0);

            if (hold_pending) begin
                check("hold_valid", 32'(instr_valid), 32'd1);
                check("hold_out", instr_out, held_out);
                check("hold_pc", instr_pc, held_pc);
            end
            hold_pending = 1'b0;

            if (imem_req) begin
                check("credit", 32'((pushed - popped + int'(resp_this)) < DEPTH), 32'd1);
                check("imem_addr", imem_addr, next_addr);
                next_addr = next_addr + 32'd4;
            end

            if (instr_valid) begin
                if (instr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr", instr_pc, 32'hDEAD_DEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_out", instr_out, e.data);
                        check("instr_pc", instr_pc, e.pc);
                    end
                    popped++;
                    if (accepted < 65535) accepted++;
                end else begin
                    hold_pending = 1'b1;
                    held_out     = instr_out;
                    held_pc      = instr_pc;
                end
            end

            if (resp_this && run_active && !halt_seen) begin
                if (resp_word == HALT) begin
                    halt_seen = 1'b1;
                end else begin
                    check("push_room", 32'((pushed - popped) < DEPTH), 32'd1);
                    pushed++;
                end
            end

            if (start && !busy) begin
                build_expected(start_pc);
                next_addr  = start_pc & 32'hFFFF_FFFC;
                pushed     = 0;
                popped     = 0;
                accepted   = 0;
                halt_seen  = 1'b0;
                run_active = 1'b1;
            end

            req_prev  = imem_req;
            addr_prev = imem_addr;
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [31:0] pc0);
        start_pc = pc0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready);
        int n;
        n = 0;
        while (busy && n < budget) begin
            if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        logic [31:0] wa, wb, wc;
        logic [31:0] base;
        int          len;

        rst_n       = 1'b0;
        start       = 1'b1;
        start_pc    = 32'h0000_1234;
        instr_ready = 1'b1;
        fill_random();

        // Reset held two cycles with start asserted.
        tick();
        tick();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd0);

        // Streaming with exact latency.
        wa = rand_word(); wb = rand_word(); wc = rand_word();
        put(32'h0, wa); put(32'h4, wb); put(32'h8, wc); put(32'hC, HALT);
        instr_ready = 1'b1;
        begin_run(32'h0);
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", 32'(instr_valid), 32'd0);
        tick();
        check("c2_valid", 32'(instr_valid), 32'd0);
        check("c2_addr", imem_addr, 32'h4);
        tick();
        check("c3_valid", 32'(instr_valid), 32'd1);
        check("c3_out", instr_out, wa);
        check("c3_pc", instr_pc, 32'h0);
        tick();
        check("c4_out", instr_out, wb);
        check("c4_pc", instr_pc, 32'h4);
        tick();
        check("c5_out", instr_out, wc);
        check("c5_pc", instr_pc, 32'h8);
        tick();
        check("c6_valid", 32'(instr_valid), 32'd0);
        wait_idle(20, 1'b0);
        check("stream_count", 32'(fetch_count), 32'd3);
        repeat (3) tick();
        check("stream_no_extra", 32'(instr_valid), 32'd0);

        // Backpressure: FIFO fills to exactly DEPTH, then drains in order.
        put_program(32'h100, 12);
        instr_ready = 1'b0;
        begin_run(32'h100);
        repeat (15) tick();
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_occupancy", 32'(pushed - popped), 32'(DEPTH));
        check("bp_head_out", instr_out, word_at(32'h100));
        check("bp_head_pc", instr_pc, 32'h100);
        check("bp_count", 32'(fetch_count), 32'd0);
        instr_ready = 1'b1;
        wait_idle(100, 1'b0);
        check("bp_total", 32'(fetch_count), 32'd12);
        check("bp_exp_left", 32'(exp_q.size()), 32'd0);

        // Address wrap with misaligned start_pc.
        put(32'hFFFF_FFFC, rand_word()); put(32'h0, rand_word()); put(32'h4, HALT);
        instr_ready = 1'b1;
        begin_run(32'hFFFF_FFFE);
        check("wrap_first_req", 32'(imem_req), 32'd1);
        check("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_second_addr", imem_addr, 32'h0);
        wait_idle(30, 1'b0);
        check("wrap_count", 32'(fetch_count), 32'd2);

        // Reset mid-run with two queued entries and a request in flight.
        put_program(32'h200, 8);
        instr_ready = 1'b0;
        begin_run(32'h200);
        repeat (3) tick();
        check("mid_occupancy", 32'(pushed - popped), 32'd2);
        check("mid_inflight", 32'(req_prev), 32'd1);
        check("mid_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_count", 32'(fetch_count), 32'd0);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_late_ignored", 32'(instr_valid), 32'd0);
        end

        // start pulsed during a run is ignored.
        put_program(32'h300, 20);
        begin_run(32'h300);
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end
        start_pc = 32'h40;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        wait_idle(300, 1'b1);
        check("restart_count", 32'(fetch_count), 32'd20);
        check("restart_exp_left", 32'(exp_q.size()), 32'd0);

        // Randomized runs, including empty programs and unaligned starts.
        for (int r = 0; r < 8; r++) begin
            fill_random();
            base = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            len  = (r == 0) ? 0 : $urandom_range(1, 25);
            put_program(base, len);
            instr_ready = 1'($urandom_range(0, 1));
            begin_run(base);
            wait_idle(400, 1'b1);
            check("rand_count", 32'(fetch_count), 32'(len));
            check("rand_exp_left", 32'(exp_q.size()), 32'd0);
            instr_ready = 1'b1;
            repeat (2) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
